// File: rtl/draw_pkg.sv
// Shared drawing definitions for the VGA path: pixel modes, engine states and
// the default screen geometry used by the VGA top, the controller and the engine.
package draw_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    FILL    = 2'd1,
    STRIPE  = 2'd2,
    CHECKER = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Nested x/y raster counter: x runs x0..x_end, then wraps and y steps.
// Bounds are captured on load so the caller may change its inputs afterwards.
module raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           enable,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x_end,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y_end,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x0_q;
  logic [X_W-1:0] x_end_q;
  logic [Y_W-1:0] y_end_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x       <= '0;
      y       <= '0;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else if (load) begin
      x       <= x0;
      y       <= y0;
      x0_q    <= x0;
      x_end_q <= x_end;
      y_end_q <= y_end;
    end else if (enable) begin
      if (x == x_end_q) begin
        x <= x0_q;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == x_end_q) && (y == y_end_q);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle raster engine: latches a clipped rectangle on start and streams one
// framebuffer write per pixel in raster order over a plot/plot_ready handshake.
module rect_fill_engine
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  input  logic [COLOR_W-1:0] fg_color,
  output logic               plot,
  input  logic               plot_ready,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);

  state_t               state;
  state_t               state_next;
  mode_t                mode_q;
  logic [COLOR_W-1:0]   fg_q;
  logic                 load;
  logic                 advance;
  logic                 last;
  logic                 empty;
  logic [X_W:0]         x_sum;
  logic [Y_W:0]         y_sum;
  logic [X_W-1:0]       x_end_c;
  logic [Y_W-1:0]       y_end_c;

  // One extra bit keeps x0+w-1 from wrapping before the clip against the screen edge.
  assign x_sum   = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
  assign y_sum   = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);
  assign x_end_c = (x_sum > X_MAX) ? X_MAX[X_W-1:0] : x_sum[X_W-1:0];
  assign y_end_c = (y_sum > Y_MAX) ? Y_MAX[Y_W-1:0] : y_sum[Y_W-1:0];
  assign empty   = (w == '0) || (h == '0) || ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);

  raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .enable (advance),
    .x0     (x0),
    .x_end  (x_end_c),
    .y0     (y0),
    .y_end  (y_end_c),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= CLEAR;
      fg_q   <= '0;
    end else if (load) begin
      mode_q <= mode_t'(mode);
      fg_q   <= fg_color;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = empty ? DONE : DRAW;
      DRAW:    if (plot_ready && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // plot depends only on state; plot_ready only gates the counter advance.
  always_comb begin
    plot    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: load = start;
      DRAW: begin
        plot    = 1'b1;
        busy    = 1'b1;
        advance = plot_ready;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    color = '0;
    case (mode_q)
      CLEAR:   color = '0;
      FILL:    color = fg_q;
      STRIPE:  color = y[COLOR_W-1:0];
      CHECKER: color = (x[0] ^ y[0]) ? fg_q : '0;
      default: color = '0;
    endcase
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: a reference raster model queues expected
// pixels per request, and a monitor pops and compares on every accepted plot.
module tb_rect_fill_engine;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOR_W = 3;
  localparam int SW = 160;
  localparam int SH = 120;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         mode;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [X_W-1:0]     w;
  logic [Y_W-1:0]     h;
  logic [COLOR_W-1:0] fg_color;
  logic               plot;
  logic               plot_ready;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               busy;
  logic               done;

  typedef struct {
    int px;
    int py;
    int pc;
  } pix_t;

  pix_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  int   stall_cnt = 0;
  bit   rand_ready = 1'b0;

  rect_fill_engine #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COLOR_W  (COLOR_W),
    .SCREEN_W (SW),
    .SCREEN_H (SH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .fg_color   (fg_color),
    .plot       (plot),
    .plot_ready (plot_ready),
    .x          (x),
    .y          (y),
    .color      (color),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int ref_color(input int m, input int fg, input int px, input int py);
    case (m)
      0:       return 0;
      1:       return fg;
      2:       return py % (1 << COLOR_W);
      default: return ((px % 2) != (py % 2)) ? fg : 0;
    endcase
  endfunction

  // Reference model: plain nested loops over the clipped rectangle.
  function automatic int model_push(input int ax0, input int ay0, input int aw, input int ah,
                                    input int am, input int afg);
    int xe, ye, n;
    pix_t p;
    n = 0;
    if (aw == 0 || ah == 0 || ax0 >= SW || ay0 >= SH) return 0;
    xe = (ax0 + aw - 1 > SW - 1) ? SW - 1 : ax0 + aw - 1;
    ye = (ay0 + ah - 1 > SH - 1) ? SH - 1 : ay0 + ah - 1;
    for (int yy = ay0; yy <= ye; yy++) begin
      for (int xx = ax0; xx <= xe; xx++) begin
        p.px = xx;
        p.py = yy;
        p.pc = ref_color(am, afg, xx, yy);
        exp_q.push_back(p);
        n++;
      end
    end
    return n;
  endfunction

  initial begin : ready_driver
    plot_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 plot_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin : monitor
    pix_t p;
    bit   prev_stall;
    int   sx, sy, sc;
    prev_stall = 1'b0;
    sx = 0;
    sy = 0;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_plot", int'(plot), 1);
          check("stall_x", int'(x), sx);
          check("stall_y", int'(y), sy);
          check("stall_color", int'(color), sc);
        end
        prev_stall = 1'b0;
        if (plot) begin
          if (plot_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_plot: got pixel (%0d,%0d), required none", x, y);
            end else begin
              p = exp_q.pop_front();
              check("pix_x", int'(x), p.px);
              check("pix_y", int'(y), p.py);
              check("pix_color", int'(color), p.pc);
            end
          end else begin
            stall_cnt++;
            prev_stall = 1'b1;
            sx = int'(x);
            sy = int'(y);
            sc = int'(color);
          end
        end
      end
    end
  end

  task automatic drive_req(input int ax0, input int ay0, input int aw, input int ah,
                           input int am, input int afg);
    x0       = X_W'(ax0);
    y0       = Y_W'(ay0);
    w        = X_W'(aw);
    h        = Y_W'(ah);
    mode     = 2'(am);
    fg_color = COLOR_W'(afg);
    start    = 1'b1;
  endtask

  // Issue one request and wait for done; optionally pulse a second start mid-draw.
  task automatic run(input int ax0, input int ay0, input int aw, input int ah,
                     input int am, input int afg, input int restart_at);
    int p, cnt, s0;
    bit timed_out;
    timed_out = 1'b0;
    @(negedge clk);
    p  = model_push(ax0, ay0, aw, ah, am, afg);
    s0 = stall_cnt;
    drive_req(ax0, ay0, aw, ah, am, afg);
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 1;
    forever begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (done) break;
      if (cnt == restart_at) drive_req(0, 0, 5, 5, 1, 3);
      if (cnt > 60000) begin
        timed_out = 1'b1;
        break;
      end
      cnt++;
    end
    start = 1'b0;
    if (timed_out) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", cnt);
      exp_q.delete();
    end else begin
      check("done_latency", cnt, 1 + p + (stall_cnt - s0));
      check("busy_at_done", int'(busy), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin : stimulus
    int a0, b0, r;
    reset = 1'b0;
    start = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_color", int'(color), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b1;

    rand_ready = 1'b0;
    run(0, 0, 160, 120, 0, 0, -1);
    run(150, 115, 20, 10, 1, 5, -1);
    run(0, 0, 2, 2, 3, 7, -1);
    run(5, 5, 0, 3, 1, 7, -1);
    run(170, 5, 4, 3, 1, 7, -1);
    run(20, 30, 4, 3, 1, 6, 3);

    rand_ready = 1'b1;
    run(10, 20, 3, 2, 2, 0, -1);

    // Reset in the middle of a draw, then a fresh request.
    rand_ready = 1'b0;
    @(negedge clk);
    a0 = acc_cnt;
    r = model_push(30, 40, 10, 3, 1, 2);
    drive_req(30, 40, 10, 3, 1, 2);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100 && acc_cnt < a0 + 5; i++) @(negedge clk);
    check("pixels_before_reset", acc_cnt - a0, 5);
    #2 reset = 1'b0;
    #1;
    check("midrst_plot", int'(plot), 0);
    check("midrst_x", int'(x), 0);
    check("midrst_y", int'(y), 0);
    check("midrst_color", int'(color), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    b0 = acc_cnt;
    run(70, 90, 4, 3, 2, 0, -1);
    check("post_reset_pixels", acc_cnt - b0, 12);

    rand_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      run($urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 20),
          $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 7), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Parametrised rectangle raster engine for the VGA drawing path: on a start pulse it latches a rectangle, mode and colour, then emits one framebuffer write per pixel in raster order (x inner, y outer) over a valid/ready handshake, clipped to the screen. It generalises the fixed full-screen sweep with black/colour select. Its outputs feed the framebuffer write port, and its start/done pair is driven by the top-level control FSM.

## Interface
- X_W, 8: x coordinate width
- Y_W, 7: y coordinate width
- COLOR_W, 3: pixel colour width
- SCREEN_W, 160: visible columns; must be ≤ 2^X_W
- SCREEN_H, 120: visible rows; must be ≤ 2^Y_W

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- mode  in  2  0 CLEAR (colour 0), 1 FILL (fg_color), 2 STRIPE (y[COLOR_W-1:0]), 3 CHECKER (fg_color if x[0]^y[0], else 0)
- x0  in  X_W  rectangle left column
- y0  in  Y_W  rectangle top row
- w  in  X_W  width in pixels
- h  in  Y_W  height in pixels
- fg_color  in  COLOR_W  foreground colour
- plot  out  1  pixel valid
- plot_ready  in  1  framebuffer accepts pixel
- x  out  X_W  pixel column
- y  out  Y_W  pixel row
- color  out  COLOR_W  pixel colour
- busy  out  1  high in DRAW
- done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: start=1 latches mode, fg_color and the clipped bounds, loads x=x0 and y=y0, then goes to DRAW. If the rectangle is empty it goes to DONE instead.
  - DRAW: plot=1. On plot&plot_ready, advance the counters. On the last pixel, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Empty rectangle: w==0, h==0, x0≥SCREEN_W or y0≥SCREEN_H. No plot is ever asserted.
- Clipping:
  - x_end = min(x0+w-1, SCREEN_W-1), computed at X_W+1 bits so it cannot overflow.
  - y_end = min(y0+h-1, SCREEN_H-1), computed the same way at Y_W+1 bits.
- Advance: if x==x_end, then x←x0 and y←y+1; otherwise x←x+1. The last pixel is x==x_end && y==y_end.
- Colour is combinational from the latched mode/fg_color and the current x/y.
- While plot=1 and plot_ready=0, x, y and color hold stable. plot never drops before acceptance.
- start is ignored in DRAW and DONE; inputs other than start and plot_ready are don't-care outside IDLE-start.
- Reset (any cycle, including mid-DRAW):
  - State returns to IDLE.
  - x=0, y=0, color=0, plot=0, busy=0, done=0.
  - Latched parameters are cleared; no partial resume.

## Timing
- start sampled at edge N: plot=1 with the first pixel (x0,y0) from cycle N+1.
- With plot_ready held high: one pixel per cycle; the k-th pixel (k from 0) is presented in cycle N+1+k.
- For P = clipped pixel count: done pulses in cycle N+1+P. busy falls in that same cycle, and start is accepted from cycle N+2+P.
- Empty rectangle: done in cycle N+1, busy stays 0.
- Each plot_ready=0 cycle during DRAW delays all later events by one cycle.
- No combinational path from plot_ready to plot; plot_ready is allowed to depend on plot.

## Structure
- Shared package draw_pkg:
  - mode_t enum (CLEAR, FILL, STRIPE, CHECKER)
  - state_t enum (IDLE, DRAW, DONE)
  - default SCREEN_W/SCREEN_H constants, reused by the VGA top and the controller
- Sub-module raster_counter:
  - parametrised nested x/y counter
  - load, enable, x0/x_end/y_end inputs
  - last-pixel flag output
  - replaces the separate column/row counters and end comparators
- The engine itself holds the FSM, the clip arithmetic and the colour mux.

## Test plan
- Full clear: x0=0, y0=0, w=160, h=120, mode CLEAR, ready=1. Expect 19200 plots in raster order, all color=0, last at (159,119); done exactly 19201 cycles after start.
- Clip: x0=150, y0=115, w=20, h=10, FILL fg=5. Expect x 150..159 and y 115..119 (50 pixels), color 5, no coordinate beyond the screen.
- Backpressure: 3×2 STRIPE at (10,20) with ready toggling randomly. Expect 6 unique pixels, outputs stable while stalled, colours 4,4,4,5,5,5.
- Empty/ignored: start with w=0 gives done in cycle N+1 with no plot. Start again during a DRAW: no effect on the pixel stream or count.
- CHECKER 2×2 at (0,0), fg=7: colours 0,7,7,0.
- Reset mid-DRAW after 5 pixels: all outputs go to 0 immediately. A new start restarts from the new x0,y0 with no stale pixels.
